// File: rtl/camera_controller.sv
`default_nettype none
// ============================================================================
// camera_controller
// Turns left/right button presses into the seven-state camera view sequence,
// with frame-paced transition states and an animation frame index.
// Revision: 1.0
// ============================================================================
module camera_controller #(
    parameter int FRAME_CYCLES = 3125000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_active,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [2:0] camera_view,
    output logic       turning,
    output logic [1:0] turn_frame,
    output logic       view_settled
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

    localparam logic [2:0] ST_FWD   = 3'b001;
    localparam logic [2:0] ST_FTOL  = 3'b010;
    localparam logic [2:0] ST_LEFT  = 3'b011;
    localparam logic [2:0] ST_LTOF  = 3'b100;
    localparam logic [2:0] ST_FTOR  = 3'b101;
    localparam logic [2:0] ST_RIGHT = 3'b110;
    localparam logic [2:0] ST_RTOF  = 3'b111;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]       turn_frame_q, turn_frame_d;
    logic             turning_q, turning_d;
    logic             settled_q, settled_d;
    logic             btn_left_q, btn_right_q;

    logic             press_l, press_r;
    logic             is_trans;
    logic [2:0]       dest;

    always_comb begin
        // Simultaneous rising edges cancel each other out.
        press_l = btn_left  & ~btn_left_q  & ~(btn_right & ~btn_right_q);
        press_r = btn_right & ~btn_right_q & ~(btn_left  & ~btn_left_q);

        is_trans = 1'b0;
        dest     = ST_FWD;
        case (state_q)
            ST_FTOL: begin is_trans = 1'b1; dest = ST_LEFT;  end
            ST_LTOF: begin is_trans = 1'b1; dest = ST_FWD;   end
            ST_FTOR: begin is_trans = 1'b1; dest = ST_RIGHT; end
            ST_RTOF: begin is_trans = 1'b1; dest = ST_FWD;   end
            default: begin is_trans = 1'b0; dest = ST_FWD;   end
        endcase

        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        turn_frame_d = turn_frame_q;
        turning_d    = turning_q;
        settled_d    = 1'b0;

        if (!game_active) begin
            state_d      = ST_FWD;
            frame_cnt_d  = '0;
            turn_frame_d = 2'd0;
            turning_d    = 1'b0;
        end else if (is_trans) begin
            if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_d = '0;
                if (turn_frame_q == 2'd3) begin
                    state_d      = dest;
                    turn_frame_d = 2'd0;
                    turning_d    = 1'b0;
                    settled_d    = 1'b1;
                end else begin
                    turn_frame_d = turn_frame_q + 2'd1;
                end
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end else begin
            frame_cnt_d  = '0;
            turn_frame_d = 2'd0;
            turning_d    = 1'b0;
            case (state_q)
                ST_FWD: begin
                    if (press_l) begin
                        state_d   = ST_FTOL;
                        turning_d = 1'b1;
                    end else if (press_r) begin
                        state_d   = ST_FTOR;
                        turning_d = 1'b1;
                    end
                end
                ST_LEFT: begin
                    if (press_r) begin
                        state_d   = ST_LTOF;
                        turning_d = 1'b1;
                    end
                end
                ST_RIGHT: begin
                    if (press_l) begin
                        state_d   = ST_RTOF;
                        turning_d = 1'b1;
                    end
                end
                default: state_d = ST_FWD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_FWD;
            frame_cnt_q  <= '0;
            turn_frame_q <= 2'd0;
            turning_q    <= 1'b0;
            settled_q    <= 1'b0;
            btn_left_q   <= 1'b1;
            btn_right_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            turn_frame_q <= turn_frame_d;
            turning_q    <= turning_d;
            settled_q    <= settled_d;
            btn_left_q   <= btn_left;
            btn_right_q  <= btn_right;
        end
    end

    assign camera_view  = state_q;
    assign turning      = turning_q;
    assign turn_frame   = turn_frame_q;
    assign view_settled = settled_q;

endmodule
`default_nettype wire

// File: tb/tb_camera_controller.sv
`default_nettype none
// ============================================================================
// tb_camera_controller
// Directed self-checking bench for camera_controller with FRAME_CYCLES = 4.
// Revision: 1.0
// ============================================================================
module tb_camera_controller;

    localparam int FRAME_CYCLES = 4;
    localparam int TURN_LEN     = 4 * FRAME_CYCLES;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       game_active;
    logic       btn_left;
    logic       btn_right;
    logic [2:0] camera_view;
    logic       turning;
    logic [1:0] turn_frame;
    logic       view_settled;

    int n_checks = 0;
    int n_pass   = 0;

    camera_controller #(.FRAME_CYCLES(FRAME_CYCLES)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .game_active  (game_active),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .camera_view  (camera_view),
        .turning      (turning),
        .turn_frame   (turn_frame),
        .view_settled (view_settled)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic l, input logic r);
        btn_left  = l;
        btn_right = r;
        tick();
        btn_left  = 1'b0;
        btn_right = 1'b0;
    endtask

    // Checks a full transition starting right after the accepting edge;
    // optionally pulses btn_left at index ign_at to prove it is ignored.
    task automatic check_turn(input logic [2:0] code, input logic [2:0] dst, input int ign_at);
        for (int i = 0; i < TURN_LEN; i++) begin
            check("trans_view", {29'd0, camera_view}, {29'd0, code});
            check("trans_frame", {30'd0, turn_frame}, i / FRAME_CYCLES);
            check("trans_turning", {31'd0, turning}, 32'd1);
            check("trans_settled", {31'd0, view_settled}, 32'd0);
            if (i == ign_at) btn_left = 1'b1;
            tick();
            btn_left = 1'b0;
        end
        check("dest_view", {29'd0, camera_view}, {29'd0, dst});
        check("dest_settled", {31'd0, view_settled}, 32'd1);
        check("dest_turning", {31'd0, turning}, 32'd0);
        check("dest_frame", {30'd0, turn_frame}, 32'd0);
        tick();
        check("settled_pulse_end", {31'd0, view_settled}, 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        game_active = 1'b1;
        btn_left    = 1'b1;
        btn_right   = 1'b0;
        repeat (3) tick();
        check("reset_view", {29'd0, camera_view}, 32'd1);
        check("reset_turning", {31'd0, turning}, 32'd0);
        check("reset_frame", {30'd0, turn_frame}, 32'd0);
        check("reset_settled", {31'd0, view_settled}, 32'd0);

        // Button held through reset release must not start a turn.
        rst_n = 1'b1;
        repeat (3) tick();
        check("held_btn_view", {29'd0, camera_view}, 32'd1);
        btn_left = 1'b0;
        tick();

        press(1'b1, 1'b0);
        check_turn(3'b010, 3'b011, -1);

        press(1'b1, 1'b0);
        check("left_ignore_l", {29'd0, camera_view}, 32'd3);
        tick();
        check("left_ignore_l2", {29'd0, camera_view}, 32'd3);

        press(1'b0, 1'b1);
        check_turn(3'b100, 3'b001, 5);
        repeat (3) tick();
        check("no_queued_turn", {29'd0, camera_view}, 32'd1);

        press(1'b1, 1'b1);
        check("both_edges", {29'd0, camera_view}, 32'd1);
        tick();
        check("both_edges2", {29'd0, camera_view}, 32'd1);

        press(1'b0, 1'b1);
        check_turn(3'b101, 3'b110, -1);
        press(1'b0, 1'b1);
        check("right_ignore_r", {29'd0, camera_view}, 32'd6);
        tick();
        check("right_ignore_r2", {29'd0, camera_view}, 32'd6);

        press(1'b1, 1'b0);
        check_turn(3'b111, 3'b001, -1);

        // Abort FtoR partway through.
        press(1'b0, 1'b1);
        repeat (7) tick();
        check("pre_abort_view", {29'd0, camera_view}, 32'd5);
        check("pre_abort_frame", {30'd0, turn_frame}, 32'd1);
        game_active = 1'b0;
        tick();
        check("abort_view", {29'd0, camera_view}, 32'd1);
        check("abort_turning", {31'd0, turning}, 32'd0);
        check("abort_frame", {30'd0, turn_frame}, 32'd0);
        check("abort_settled", {31'd0, view_settled}, 32'd0);
        tick();
        check("abort_settled2", {31'd0, view_settled}, 32'd0);

        press(1'b1, 1'b0);
        check("inactive_press", {29'd0, camera_view}, 32'd1);

        // A press held across game_active rising must not fire.
        btn_right = 1'b1;
        tick();
        game_active = 1'b1;
        repeat (2) tick();
        check("held_across_active", {29'd0, camera_view}, 32'd1);
        btn_right = 1'b0;
        tick();

        press(1'b1, 1'b0);
        check("post_abort_turn", {29'd0, camera_view}, 32'd2);
        check("post_abort_turning", {31'd0, turning}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/camera_controller.md
# camera_controller

Turn sequencer that produces the 3-bit `camera_view` code consumed by the rendering controller. It converts left/right turn button presses into the seven-state view sequence (Forward, FtoL, Left, LtoF, FtoR, Right, RtoF). Each transition state holds for a fixed, frame-paced interval and exposes an animation frame index. The block sits between the debounced button inputs and the renderer, and also feeds the enemy logic, which uses it to decide which directional flag is visible.

## Interface
- `FRAME_CYCLES`, default 3125000: clock cycles per turn-animation frame (0.125 s at 25 MHz). Must be ≥ 2.
- `clk`  in  1  system clock, the same clock the renderer's ROMs use.
- `rst_n`  in  1  reset, synchronous, active-low. This is the single clock/reset domain.
- `game_active`  in  1  high while gameplay runs. While low, the view is forced to Forward.
- `btn_left`  in  1  debounced level, active-high.
- `btn_right`  in  1  debounced level, active-high.
- `camera_view`  out  3  view code: Forward=001, FtoL=010, Left=011, LtoF=100, FtoR=101, Right=110, RtoF=111. The value 000 is never driven.
- `turning`  out  1  high while `camera_view` is a transition state.
- `turn_frame`  out  2  animation frame 0..3 within a transition; 0 when not turning.
- `view_settled`  out  1  one-cycle pulse on entry into Forward, Left or Right from a transition.

## Operation
- **Edge detection.**
  - `btn_*_q` registers hold the previous button levels. They reset to 1, so a button already held at reset release does not fire.
  - `press_l = btn_left & ~btn_left_q`, `press_r = btn_right & ~btn_right_q`.
  - If `press_l` and `press_r` occur in the same cycle, both are discarded.
- **Steady states.** These accept presses only when `game_active = 1`. Presses are never queued.
  - Forward: press_l → FtoL; press_r → FtoR.
  - Left: press_r → LtoF; press_l is ignored.
  - Right: press_l → RtoF; press_r is ignored.
- **Transition states.**
  - FtoL → Left, LtoF → Forward, FtoR → Right, RtoF → Forward.
  - Each transition lasts exactly 4×`FRAME_CYCLES` cycles.
  - All presses during a transition are ignored.
- **Frame counter.**
  - `frame_cnt` is $clog2(`FRAME_CYCLES`) bits wide and runs alongside a 2-bit `turn_frame`.
  - On entering a transition, both clear to 0.
  - Each cycle in a transition, `frame_cnt` increments.
  - When `frame_cnt` = `FRAME_CYCLES`−1: `frame_cnt` wraps to 0 and `turn_frame` increments.
  - When `turn_frame` = 3 at that wrap point, the state advances to its destination, `turn_frame` returns to 0, and `view_settled` pulses.
- **game_active low.**
  - Takes priority over everything, including mid-transition.
  - Next cycle: Forward, counters at 0, `turning` = 0.
  - `view_settled` does not pulse for this forced return.
  - The edge registers keep updating, so a press held across the rising edge of `game_active` does not fire.
- **Outputs.** All outputs are registered. `turning` and `turn_frame` are consistent with `camera_view` in every cycle.

## Timing
- **Reset** (`rst_n` low at a clock edge):
  - `camera_view` = 001, `turning` = 0, `turn_frame` = 0, `view_settled` = 0, counters = 0.
  - Reset asserted mid-transition aborts it the same way.
- **Press latency.** If a button is sampled high at edge N with the previous level low, `camera_view` shows the transition code after edge N. That is one cycle of latency from the sampled edge.
- **Transition duration.**
  - The transition code is visible for exactly 4×`FRAME_CYCLES` cycles.
  - `turn_frame` = k for exactly `FRAME_CYCLES` cycles each, k = 0..3.
  - The destination code and the `view_settled` pulse appear on the same edge.
- **Back-to-back presses.** A new press is accepted on the first cycle the steady state is visible, so the minimum spacing between accepted presses is 4×`FRAME_CYCLES` + 1 cycles.

## Test plan
Directed tests use `FRAME_CYCLES` = 4 unless noted.
- **Reset.** Hold `rst_n` = 0 with `btn_left` = 1 and release. Required: `camera_view` = 001; no transition starts while the button stays held.
- **Left turn.** With `game_active` = 1, pulse `btn_left` for 1 cycle. Required:
  - `camera_view` = 010 for exactly 16 cycles.
  - `turn_frame` steps 0,1,2,3, four cycles each.
  - Then `camera_view` = 011 with a single-cycle `view_settled`.
- **Round trip and ignored presses.**
  - From Left, press `btn_left`: required no change.
  - Press `btn_right`: required 100 for 16 cycles, then 001.
  - Press `btn_left` during LtoF: required it is ignored, with no queued turn afterward.
- **Simultaneous and illegal edges.**
  - From Forward, rising edges on both buttons in the same cycle: required it stays at 001.
  - From Right (110), press `btn_right`: required it stays at 110.
- **Abort.** At cycle 7 of FtoR, drive `game_active` = 0. Required: next cycle shows 001, `turning` = 0, `turn_frame` = 0, no `view_settled` pulse.
- **Default timing.** With `FRAME_CYCLES` = 3125000, a right turn holds 101 for exactly 12,500,000 cycles before 110 appears.
